// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam int unsigned FETCH_PC_INC   = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // Opcode class in instr[27:26] selecting a 12-bit memory offset.
  localparam logic [1:0]  OPC_CLASS_MEM  = 2'b01;

  function automatic logic is_mem_class(input logic [1:0] cls);
    return cls == OPC_CLASS_MEM;
  endfunction

endpackage

// File: rtl/fetch_ir_reg.sv
// Instruction register toward decode: IR, its PC, the valid flag and the
// immediate-field decode feeding the immediate extender.
module fetch_ir_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              squash_i,
  input  logic              id_ready_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [11:0]       imm_field_o,
  output logic              imm_len_sel_o
);

  logic              valid_q, valid_d;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] pc_q;

  // Squash beats load beats consume; load and consume never coincide.
  always_comb begin
    valid_d = valid_q;
    if (squash_i)                  valid_d = 1'b0;
    else if (load_i)               valid_d = 1'b1;
    else if (valid_q && id_ready_i) valid_d = 1'b0;
  end

  // IR storage; contents only change on an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        ir_q <= instr_i;
        pc_q <= pc_i;
      end
    end
  end

  assign valid_o       = valid_q;
  assign instr_o       = ir_q;
  assign pc_o          = pc_q;
  assign imm_field_o   = ir_q[11:0];
  assign imm_len_sel_o = is_mem_class(ir_q[27:26]);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack FSM, branch redirect/squash.
// Optional macro FETCH_PERF_CNT_EN adds fetch and stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int unsigned       PC_INC   = FETCH_PC_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [11:0]       imm_field,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              imm_len_sel
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              ir_load;

  // Next-state logic; a branch overrides the PC in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_load    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = br_valid ? br_target : pc_q;
      end
      REQ: begin
        if (br_valid) begin
          state_d = imem_ack ? WAIT : FLUSH;
        end else if (imem_ack) begin
          ir_load = 1'b1;
          pc_d    = pc_q + ADDR_W'(PC_INC);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!br_valid && (!if_valid || id_ready)) begin
          state_d    = REQ;
          req_addr_d = pc_q;
        end
      end
      FLUSH: begin
        // Old request must still complete; its data is dropped.
        if (imem_ack) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (br_valid) pc_d = br_target;
  end

  // FSM, PC and request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_req  = (state_q == REQ) || (state_q == FLUSH);
  assign imem_addr = req_addr_q;

  fetch_ir_reg #(.ADDR_W(ADDR_W)) u_ir (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ir_load),
    .squash_i     (br_valid),
    .id_ready_i   (id_ready),
    .instr_i      (imem_rdata),
    .pc_i         (req_addr_q),
    .valid_o      (if_valid),
    .instr_o      (if_instr),
    .pc_o         (if_pc),
    .imm_field_o  (imm_field),
    .imm_len_sel_o(imm_len_sel)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Accepted fetches and decode back-pressure cycles, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ir_load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == WAIT && if_valid && !id_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Inputs change and outputs are sampled
// on the falling clock edge, so each check sees the state after a rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [11:0] imm_field;
  logic        imm_len_sel;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .imm_field  (imm_field),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .imm_len_sel(imm_len_sel)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Stimulus only: pulse reset and let the FSM reach REQ at RESET_PC.
  task automatic restart();
    imem_ack = 1'b0; br_valid = 1'b0; id_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    total_cnt++;
    if ({imem_req, imem_addr, if_valid, if_instr, if_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0})
      $display("FAIL reset_state: got req=%b addr=%h v=%b ir=%h pc=%h, want all zero",
               imem_req, imem_addr, if_valid, if_instr, if_pc);
    else pass_cnt++;
    total_cnt++;
    if ({imm_field, imm_len_sel} !== 13'h0)
      $display("FAIL reset_imm: got imm=%h sel=%b want 0/0", imm_field, imm_len_sel);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'(4*k), 1'b0})
        $display("FAIL seq_req%0d: got req=%b addr=%h v=%b want 1/%h/0",
                 k, imem_req, imem_addr, if_valid, 32'(4*k));
      else pass_cnt++;
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000 | 32'(k);
      tick();
      // ack left high while idle; it must be ignored
      imem_rdata = 32'hBAD0_BAD0;
      total_cnt++;
      if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'(4*k), 32'hA000_0000 | 32'(k)})
        $display("FAIL seq_ir%0d: got req=%b v=%b pc=%h ir=%h", k, imem_req, if_valid, if_pc, if_instr);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = 32'hE59F_1004; id_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc, imm_field, imm_len_sel} !== {1'b1, 32'h10, 12'h004, 1'b1})
      $display("FAIL stall_imm12: got v=%b pc=%h imm=%h sel=%b want 1/10/004/1",
               if_valid, if_pc, imm_field, imm_len_sel);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({imem_req, if_valid, if_instr} !== {1'b0, 1'b1, 32'hE59F_1004})
        $display("FAIL stall_hold%0d: got req=%b v=%b ir=%h", i, imem_req, if_valid, if_instr);
      else pass_cnt++;
    end
    id_ready = 1'b1;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h14, 1'b0})
      $display("FAIL stall_resume: got req=%b addr=%h v=%b want 1/14/0", imem_req, imem_addr, if_valid);
    else pass_cnt++;
  endtask

  task automatic test_imm8();
    imem_ack = 1'b1; imem_rdata = 32'hE3A0_00FF; id_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if ({if_pc, imm_field, imm_len_sel} !== {32'h14, 12'h0FF, 1'b0})
      $display("FAIL imm8: got pc=%h imm=%h sel=%b want 14/0ff/0", if_pc, imm_field, imm_len_sel);
    else pass_cnt++;
    id_ready = 1'b1;
    tick();
  endtask

  task automatic test_branch_flush();
    restart();
    imem_ack = 1'b1; id_ready = 1'b1; imem_rdata = 32'h1234_5678;
    repeat (4) tick();
    imem_ack = 1'b0;
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8})
      $display("FAIL flush_pre: got req=%b addr=%h want 1/8", imem_req, imem_addr);
    else pass_cnt++;
    br_valid = 1'b1; br_target = 32'h100;
    tick();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h8, 1'b0})
        $display("FAIL flush_hold%0d: got req=%b addr=%h v=%b want 1/8/0", i, imem_req, imem_addr, if_valid);
      else pass_cnt++;
      if (i == 2) begin
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    imem_ack = 1'b0;
    total_cnt++;
    if ({imem_req, if_valid} !== 2'b00)
      $display("FAIL flush_discard: got req=%b v=%b want 0/0", imem_req, if_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL flush_target: got req=%b addr=%h v=%b want 1/100/0", imem_req, imem_addr, if_valid);
    else pass_cnt++;
  endtask

  task automatic test_branch_ack();
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; br_valid = 1'b1; br_target = 32'h200; id_ready = 1'b1;
    tick();
    imem_ack = 1'b0; br_valid = 1'b0;
    total_cnt++;
    if ({imem_req, if_valid} !== 2'b00)
      $display("FAIL brack_drop: got req=%b v=%b want 0/0", imem_req, if_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h200})
      $display("FAIL brack_target: got req=%b addr=%h want 1/200", imem_req, imem_addr);
    else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc} !== {1'b1, 32'h200})
      $display("FAIL brwait_load: got v=%b pc=%h want 1/200", if_valid, if_pc);
    else pass_cnt++;
    br_valid = 1'b1; br_target = 32'h300;
    tick();
    br_valid = 1'b0;
    total_cnt++;
    if ({imem_req, if_valid} !== 2'b00)
      $display("FAIL brwait_squash: got req=%b v=%b want 0/0", imem_req, if_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h300})
      $display("FAIL brwait_target: got req=%b addr=%h want 1/300", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    imem_ack = 1'b0; br_valid = 1'b0;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_top: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_ir: got v=%b pc=%h want 1/fffffffc", if_valid, if_pc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_zero: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({imem_req, if_valid, if_instr} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL rstmid_async: got req=%b v=%b ir=%h want 0/0/0", imem_req, if_valid, if_instr);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL rstmid_refetch: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    imem_ack = 1'b0;
    total_cnt++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h4444_4444})
      $display("FAIL rstmid_ir: got v=%b pc=%h ir=%h", if_valid, if_pc, if_instr);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_imm8();
    test_branch_flush();
    test_branch_ack();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
